// File: rtl/conv33_stream_ctrl_pkg.sv
// Shared types for the 3x3 convolution stream controller: FSM states,
// kernel size and the window tag carried through the latency-matching delay line.
package conv33_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } ctrl_state_t;

    localparam int KSIZE     = 3;
    // Tag coordinates are sized for the largest supported image edge (up to 2^16 - 1 pixels).
    localparam int TAG_DIM_W = 16;

    typedef struct packed {
        logic                 valid;
        logic [TAG_DIM_W-1:0] x;
        logic [TAG_DIM_W-1:0] y;
    } win_tag_t;

endpackage

// File: rtl/conv33_stream_ctrl_if.sv
// Host-side handshake plus datapath strobes of the conv33 stream controller.
// master = host sequencer / datapath side, slave = controller.
interface conv33_stream_ctrl_if #(
    parameter int CW = 6,
    parameter int RW = 6
);
    logic          start;
    logic          busy;
    logic          done;
    logic          in_inst_input_read_valid;
    logic          out_inst_output_write_en;
    logic [CW-1:0] out_x;
    logic [RW-1:0] out_y;

    modport master (
        output start,
        input  busy,
        input  done,
        input  in_inst_input_read_valid,
        input  out_inst_output_write_en,
        input  out_x,
        input  out_y
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output in_inst_input_read_valid,
        output out_inst_output_write_en,
        output out_x,
        output out_y
    );
endinterface

// File: rtl/conv33_stream_ctrl_delay.sv
// Fixed-depth register delay line with synchronous reset to zero; depth 0 is a wire.
// Aligns the window tag with the datapath's input register latency.
module ctrl_delay_line
    import conv33_ctrl_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = $bits(win_tag_t)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset;
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe_q [DEPTH];
            logic [WIDTH-1:0] pipe_d [DEPTH];

            always_comb begin
                pipe_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (reset) begin
                        pipe_q[i] <= '0;
                    end else begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign dout = pipe_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/conv33_stream_ctrl.sv
// Frame sequencer for the naive 3x3 convolution datapath: streams one raster image
// at one pixel per cycle and strobes write_en only for complete 3x3 windows.
module conv33_stream_ctrl
    import conv33_ctrl_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int IN_LAT = 1,
    parameter int CW     = $clog2(IMG_W),
    parameter int RW     = $clog2(IMG_H)
) (
    input  logic                clk,
    input  logic                reset,
    conv33_stream_ctrl_if.slave ctrl
);

    localparam int DCW = (IN_LAT > 1) ? $clog2(IN_LAT) : 1;

    ctrl_state_t    state_q, state_d;
    logic [CW-1:0]  col_q, col_d;
    logic [RW-1:0]  row_q, row_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           rv_q, rv_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    win_tag_t       tag_q, tag_d;
    win_tag_t       tag_dly;
    logic           last_pix;
    logic [CW-1:0]  x_rel;
    logic [RW-1:0]  y_rel;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        drain_d  = drain_q;
        last_pix = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));

        case (state_q)
            IDLE: begin
                col_d = '0;
                row_d = '0;
                if (ctrl.start) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (col_q == CW'(IMG_W - 1)) begin
                    col_d = '0;
                    row_d = row_q + 1'b1;
                end else begin
                    col_d = col_q + 1'b1;
                end
                if (last_pix) begin
                    col_d = '0;
                    row_d = '0;
                    if (IN_LAT == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DCW'(IN_LAT - 1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rv_d   = (state_d == STREAM);
        busy_d = (state_d == STREAM) || (state_d == DRAIN);
        done_d = (state_d == DONE);

        // Tag is computed for the pixel read next cycle, so it lines up with rv_q.
        x_rel = col_d - CW'(KSIZE - 1);
        y_rel = row_d - RW'(KSIZE - 1);
        tag_d = '0;
        if ((state_d == STREAM) && (col_d >= CW'(KSIZE - 1)) && (row_d >= RW'(KSIZE - 1))) begin
            tag_d.valid = 1'b1;
            tag_d.x     = TAG_DIM_W'(x_rel);
            tag_d.y     = TAG_DIM_W'(y_rel);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            drain_q <= '0;
            rv_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            rv_q    <= rv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tag_q   <= tag_d;
        end
    end

    ctrl_delay_line #(
        .DEPTH (IN_LAT),
        .WIDTH ($bits(win_tag_t))
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .din   (tag_q),
        .dout  (tag_dly)
    );

    logic tag_unused;
    assign tag_unused = ^{tag_dly.x[TAG_DIM_W-1:CW], tag_dly.y[TAG_DIM_W-1:RW]};

    assign ctrl.in_inst_input_read_valid = rv_q;
    assign ctrl.busy                     = busy_q;
    assign ctrl.done                     = done_q;
    assign ctrl.out_inst_output_write_en = tag_dly.valid;
    assign ctrl.out_x                    = tag_dly.x[CW-1:0];
    assign ctrl.out_y                    = tag_dly.y[RW-1:0];

endmodule

// File: tb/tb_conv33_stream_ctrl.sv
// Directed bench for conv33_stream_ctrl: 8x6 and 3x3 frames with IN_LAT=1, a 4x3
// frame with IN_LAT=0, mid-frame reset, ignored start, and back-to-back frames.
module tb_conv33_stream_ctrl;

    logic clk;
    logic reset;

    conv33_stream_ctrl_if #(.CW(3), .RW(3)) ifa ();
    conv33_stream_ctrl_if #(.CW(2), .RW(2)) ifb ();
    conv33_stream_ctrl_if #(.CW(2), .RW(2)) ifc ();

    conv33_stream_ctrl #(.IMG_W(8), .IMG_H(6), .IN_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .ctrl(ifa.slave));
    conv33_stream_ctrl #(.IMG_W(3), .IMG_H(3), .IN_LAT(1)) dut_b (
        .clk(clk), .reset(reset), .ctrl(ifb.slave));
    conv33_stream_ctrl #(.IMG_W(4), .IMG_H(3), .IN_LAT(0)) dut_c (
        .clk(clk), .reset(reset), .ctrl(ifc.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int n_rd, rd_first, rd_last, n_wr, wr_first, wr_last;
    int wx_first, wy_first, wx_last, wy_last;
    int n_done, done_cyc, busy_err, model_err, zero_err;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sample(input int sel, output int rv, output int we, output int bz,
                          output int dn, output int x, output int y);
        case (sel)
            0: begin
                rv = int'(ifa.in_inst_input_read_valid); we = int'(ifa.out_inst_output_write_en);
                bz = int'(ifa.busy); dn = int'(ifa.done); x = int'(ifa.out_x); y = int'(ifa.out_y);
            end
            1: begin
                rv = int'(ifb.in_inst_input_read_valid); we = int'(ifb.out_inst_output_write_en);
                bz = int'(ifb.busy); dn = int'(ifb.done); x = int'(ifb.out_x); y = int'(ifb.out_y);
            end
            default: begin
                rv = int'(ifc.in_inst_input_read_valid); we = int'(ifc.out_inst_output_write_en);
                bz = int'(ifc.busy); dn = int'(ifc.done); x = int'(ifc.out_x); y = int'(ifc.out_y);
            end
        endcase
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       ifa.start = v;
            1:       ifb.start = v;
            default: ifc.start = v;
        endcase
    endtask

    // Cycle 0 is the cycle in which start is sampled high; outputs observed at negedge.
    task automatic run_frame(input int sel, input int w, input int h, input int lat,
                             input int rst_at, input bit pulse_again);
        int n, rv, we, bz, dn, x, y, p, exp_we;
        n = w * h;
        n_rd = 0; rd_first = 0; rd_last = 0; n_wr = 0; wr_first = 0; wr_last = 0;
        wx_first = -1; wy_first = -1; wx_last = -1; wy_last = -1;
        n_done = 0; done_cyc = 0; busy_err = 0; model_err = 0; zero_err = 0;
        @(negedge clk);
        set_start(sel, 1'b1);
        for (int c = 1; c <= n + lat + 3; c++) begin
            @(negedge clk);
            sample(sel, rv, we, bz, dn, x, y);
            if (rst_at != 0 && c > rst_at) begin
                if (rv != 0 || we != 0 || bz != 0 || dn != 0 || x != 0 || y != 0) zero_err++;
            end else begin
                if (bz != ((c <= n + lat) ? 1 : 0)) busy_err++;
                p = c - lat - 1;
                exp_we = (p >= 0 && p < n && (p % w) >= 2 && (p / w) >= 2) ? 1 : 0;
                if (we != exp_we) model_err++;
                else if (we != 0 && (x != (p % w) - 2 || y != (p / w) - 2)) model_err++;
            end
            if (rv != 0) begin
                n_rd++;
                if (rd_first == 0) rd_first = c;
                rd_last = c;
            end
            if (we != 0) begin
                n_wr++;
                if (wr_first == 0) begin
                    wr_first = c; wx_first = x; wy_first = y;
                end
                wr_last = c; wx_last = x; wy_last = y;
            end
            if (dn != 0) begin
                n_done++;
                done_cyc = c;
            end
            if (c == 1) set_start(sel, 1'b0);
            if (pulse_again && c == 10) set_start(sel, 1'b1);
            if (pulse_again && c == 11) set_start(sel, 1'b0);
            if (rst_at != 0 && c == rst_at) reset = 1'b1;
            if (rst_at != 0 && c == rst_at + 1) reset = 1'b0;
        end
    endtask

    initial begin
        int rv, we, bz, dn, x, y, nrd, ndn, d1, r2;
        reset = 1'b1;
        ifa.start = 1'b0; ifb.start = 1'b0; ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        sample(0, rv, we, bz, dn, x, y);
        check_eq("rst_read_valid", rv, 0);
        check_eq("rst_write_en", we, 0);
        check_eq("rst_busy", bz, 0);
        check_eq("rst_done", dn, 0);
        check_eq("rst_out_x", x, 0);
        check_eq("rst_out_y", y, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(0, 8, 6, 1, 0, 1'b0);
        check_eq("a_reads", n_rd, 48);
        check_eq("a_first_read", rd_first, 1);
        check_eq("a_last_read", rd_last, 48);
        check_eq("a_writes", n_wr, 24);
        check_eq("a_first_write_cyc", wr_first, 20);
        check_eq("a_first_write_x", wx_first, 0);
        check_eq("a_first_write_y", wy_first, 0);
        check_eq("a_last_write_cyc", wr_last, 49);
        check_eq("a_last_write_x", wx_last, 5);
        check_eq("a_last_write_y", wy_last, 3);
        check_eq("a_done_count", n_done, 1);
        check_eq("a_done_cyc", done_cyc, 50);
        check_eq("a_busy_profile", busy_err, 0);
        check_eq("a_write_schedule", model_err, 0);

        run_frame(1, 3, 3, 1, 0, 1'b0);
        check_eq("b_reads", n_rd, 9);
        check_eq("b_writes", n_wr, 1);
        check_eq("b_write_cyc", wr_first, 10);
        check_eq("b_write_x", wx_first, 0);
        check_eq("b_write_y", wy_first, 0);
        check_eq("b_done_cyc", done_cyc, 11);
        check_eq("b_busy_profile", busy_err, 0);

        run_frame(2, 4, 3, 0, 0, 1'b0);
        check_eq("c_reads", n_rd, 12);
        check_eq("c_writes", n_wr, 2);
        check_eq("c_first_write_cyc", wr_first, 11);
        check_eq("c_last_write_cyc", wr_last, 12);
        check_eq("c_last_write_x", wx_last, 1);
        check_eq("c_last_write_y", wy_last, 0);
        check_eq("c_done_cyc", done_cyc, 13);
        check_eq("c_busy_profile", busy_err, 0);
        check_eq("c_write_schedule", model_err, 0);

        run_frame(0, 8, 6, 1, 20, 1'b0);
        check_eq("abort_reads", n_rd, 20);
        check_eq("abort_writes", n_wr, 1);
        check_eq("abort_done", n_done, 0);
        check_eq("abort_outputs_zero", zero_err, 0);

        run_frame(0, 8, 6, 1, 0, 1'b0);
        check_eq("post_abort_reads", n_rd, 48);
        check_eq("post_abort_writes", n_wr, 24);
        check_eq("post_abort_done", n_done, 1);
        check_eq("post_abort_schedule", model_err, 0);

        run_frame(0, 8, 6, 1, 0, 1'b1);
        check_eq("restart_reads", n_rd, 48);
        check_eq("restart_done_count", n_done, 1);
        check_eq("restart_done_cyc", done_cyc, 50);
        check_eq("restart_schedule", model_err, 0);

        nrd = 0; ndn = 0; d1 = 0; r2 = 0;
        @(negedge clk);
        ifa.start = 1'b1;
        for (int c = 1; c <= 102; c++) begin
            @(negedge clk);
            sample(0, rv, we, bz, dn, x, y);
            if (rv != 0) begin
                nrd++;
                if (d1 != 0 && r2 == 0) r2 = c;
            end
            if (dn != 0) begin
                ndn++;
                if (d1 == 0) d1 = c;
            end
            if (c == 102) ifa.start = 1'b0;
        end
        check_eq("held_reads", nrd, 96);
        check_eq("held_done_count", ndn, 2);
        check_eq("held_first_done", d1, 50);
        check_eq("held_second_read", r2, 52);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
